// File: rtl/pipe_clk_ctrl.sv
// pipe_clk_ctrl
//   Run / single-step / breakpoint controller for the pipelined CPU. The
//   whole pipeline runs on clk and advances only on cycles where cpu_ce is
//   high. In RUN, cpu_ce is issued once every div_reg+1 clk cycles. In HALT
//   and BRK, cpu_ce is issued once per debounced press of step_btn. A
//   breakpoint match on the tick that would have advanced the pipeline
//   parks the controller in BRK instead.
//
// Ports
//   clk        in   1      system clock
//   rst        in   1      asynchronous, active-high reset
//   run_sw     in   1      asynchronous run level (1 = run, 0 = halt)
//   step_btn   in   1      asynchronous raw push button
//   div_load   in   1      pulse: load div_value into div_reg and clear cnt
//   div_value  in   DIV_W  new divide value (ce period = value + 1)
//   bp_en      in   1      breakpoint enable
//   bp_addr    in   PC_W   breakpoint PC
//   pc         in   PC_W   PC of the next instruction to be fetched
//   cpu_ce     out  1      registered one-cycle pipeline enable
//   state      out  2      0 = HALT, 1 = RUN, 2 = BRK
//   halted     out  1      registered (state != RUN)
//   ce_count   out  16     count of issued cpu_ce pulses, wraps modulo 2^16
module pipe_clk_ctrl #(
  parameter int DIV_W       = 25,
  parameter int DEFAULT_DIV = 3,
  parameter int DB_CYCLES   = 16,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             halted,
  output logic [15:0]      ce_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_BRK  = 2'd2
  } state_t;

  localparam int              DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  // Two-flop synchronizers
  logic run_p0, run_s;
  logic btn_p0, btn_s;

  // Debounce
  logic [DB_W-1:0] db_cnt;
  logic            btn_db;
  logic            btn_db_p1;
  logic            step_req;

  // Control FSM
  state_t          state_q, state_nx;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_q, cnt_nx;
  logic            ce_nx;
  logic            tick;
  logic            bp_hit;
  logic            halted_q;
  logic [15:0]     ce_count_q;

  // ---- stage 0/1: bring asynchronous inputs into the clk domain ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_p0 <= 1'b0;
      run_s  <= 1'b0;
      btn_p0 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      run_p0 <= run_sw;
      run_s  <= run_p0;
      btn_p0 <= step_btn;
      btn_s  <= btn_p0;
    end
  end

  // ---- debounce: accept btn_s only after DB_CYCLES consecutive cycles of
  //      disagreement with the accepted level; any bounce restarts the run ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_db    <= 1'b0;
      btn_db_p1 <= 1'b0;
    end else begin
      btn_db_p1 <= btn_db;
      if (btn_s != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= btn_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // One-cycle pulse on the accepted press edge.
  assign step_req = btn_db & ~btn_db_p1;

  // ---- FSM next-state / enable decision ----
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    ce_nx    = 1'b0;
    tick     = 1'b0;
    bp_hit   = bp_en && (pc == bp_addr);

    unique case (state_q)
      ST_HALT: begin
        // A run request beats a coincident step; the step is dropped.
        if (run_s) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else if (step_req) begin
          ce_nx = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_s) begin
          state_nx = ST_HALT;
        end else if (cnt_q == div_reg) begin
          cnt_nx = '0;
          tick   = 1'b1;
        end else begin
          cnt_nx = cnt_q + DIV_W'(1);
        end
      end
      ST_BRK: begin
        // Only a low-then-high run_sw leaves BRK; a held-high run_sw keeps
        // the pipeline parked so it can be stepped past the breakpoint.
        if (!run_s) begin
          state_nx = ST_HALT;
        end else if (step_req) begin
          ce_nx = 1'b1;
        end
      end
      default: begin
        state_nx = ST_HALT;
      end
    endcase

    // A divider reload cancels a coincident tick, including any breakpoint
    // decision that tick would have made.
    if (tick && !div_load) begin
      if (bp_hit) begin
        state_nx = ST_BRK;
      end else begin
        ce_nx = 1'b1;
      end
    end

    if (div_load) begin
      cnt_nx = '0;
    end
  end

  // ---- stage 2: registered state, enable and counters ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HALT;
      cnt_q      <= '0;
      div_reg    <= DIV_RST;
      cpu_ce     <= 1'b0;
      halted_q   <= 1'b1;
      ce_count_q <= '0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      cpu_ce     <= ce_nx;
      halted_q   <= (state_nx != ST_RUN);
      ce_count_q <= ce_count_q + {15'd0, cpu_ce};
      if (div_load) begin
        div_reg <= div_value;
      end
    end
  end

  assign state    = state_q;
  assign halted   = halted_q;
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_pipe_clk_ctrl.sv
// Bench for pipe_clk_ctrl (DEFAULT_DIV = 3, DB_CYCLES = 4).
module tb_pipe_clk_ctrl;

  localparam int DIV_W = 25;
  localparam int PC_W  = 32;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_sw;
  logic             step_btn;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             cpu_ce;
  logic [1:0]       state;
  logic             halted;
  logic [15:0]      ce_count;

  always #5 clk = ~clk;

  pipe_clk_ctrl #(
    .DIV_W(DIV_W), .DEFAULT_DIV(3), .DB_CYCLES(DB), .PC_W(PC_W)
  ) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
    .div_load(div_load), .div_value(div_value), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_ce(cpu_ce), .state(state),
    .halted(halted), .ce_count(ce_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic set_in(input logic r, input logic s, input logic ld, input logic [DIV_W-1:0] dv,
                        input logic be, input logic [PC_W-1:0] ba, input logic [PC_W-1:0] p);
    run_sw = r; step_btn = s; div_load = ld; div_value = dv;
    bp_en = be; bp_addr = ba; pc = p;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic             run_sw;
    logic             step_btn;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    int               ncyc;
    logic             exp_ce;
    logic [1:0]       exp_state;
    logic             exp_halted;
    logic [15:0]      exp_count;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic s, input logic ld, input int dv,
                              input logic be, input int ba, input int p, input int n,
                              input logic ce, input int st, input logic h, input int cnt);
    vec_t v;
    v.run_sw = r; v.step_btn = s; v.div_load = ld; v.div_value = DIV_W'(dv);
    v.bp_en = be; v.bp_addr = PC_W'(ba); v.pc = PC_W'(p); v.ncyc = n;
    v.exp_ce = ce; v.exp_state = 2'(st); v.exp_halted = h; v.exp_count = 16'(cnt);
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  localparam int M_HALT = 0, M_RUN = 1, M_BRK = 2;
  bit          m_run_q[$];
  bit          m_btn_q[$];
  bit          m_btn_acc;
  int          m_diff_len;
  bit          m_step_pending;
  int          m_state;
  int unsigned m_div, m_cnt;
  logic        m_ce;
  logic [15:0] m_count;

  task automatic model_reset();
    m_run_q.delete(); m_run_q.push_back(1'b0); m_run_q.push_back(1'b0);
    m_btn_q.delete(); m_btn_q.push_back(1'b0); m_btn_q.push_back(1'b0);
    m_btn_acc = 0; m_diff_len = 0; m_step_pending = 0;
    m_state = M_HALT; m_div = 3; m_cnt = 0; m_ce = 1'b0; m_count = '0;
  endtask

  // Predict the outputs after the next clock edge from the inputs now applied.
  task automatic model_step();
    bit run_s, btn_s, step, tick;
    run_s = m_run_q.pop_front();
    btn_s = m_btn_q.pop_front();
    m_run_q.push_back(run_sw);
    m_btn_q.push_back(step_btn);
    step = m_step_pending;
    m_count = m_count + 16'(m_ce);
    m_ce = 1'b0;
    tick = 0;
    case (m_state)
      M_HALT: if (run_s) begin m_state = M_RUN; m_cnt = 0; end
              else if (step) m_ce = 1'b1;
      M_RUN: begin
        if (!run_s) m_state = M_HALT;
        else if (m_cnt == m_div) begin m_cnt = 0; tick = 1; end
        else m_cnt = m_cnt + 1;
        if (tick && !div_load) begin
          if (bp_en && pc == bp_addr) m_state = M_BRK;
          else m_ce = 1'b1;
        end
      end
      default: if (!run_s) m_state = M_HALT;
               else if (step) m_ce = 1'b1;
    endcase
    if (div_load) begin m_div = div_value; m_cnt = 0; end
    m_step_pending = 0;
    if (btn_s != m_btn_acc) begin
      m_diff_len++;
      if (m_diff_len == DB) begin
        m_btn_acc = btn_s;
        m_diff_len = 0;
        m_step_pending = btn_s;
      end
    end else begin
      m_diff_len = 0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int pulses, snap, n, gap;
    //                 run st ld dv be  ba    pc   n  ce st h  cnt
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,    0,    1, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0,    0,    2, 0, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0,    0,    4, 1, 1, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0,    0,    1, 0, 1, 0, 1);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0,    0,    3, 1, 1, 0, 1);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0,    0,   13, 0, 1, 0, 5);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0,    0,    2, 0, 1, 0, 5);
    vecs[7]  = mk(1, 0, 1, 0, 0, 0,    0,    1, 0, 1, 0, 5);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0,    0,    1, 1, 1, 0, 5);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0,    0,    1, 1, 1, 0, 6);
    vecs[10] = mk(1, 0, 0, 0, 0, 0,    0,    5, 1, 1, 0, 11);
    vecs[11] = mk(1, 0, 0, 0, 1, 'h40, 'h3C, 1, 1, 1, 0, 12);
    vecs[12] = mk(1, 0, 0, 0, 1, 'h40, 'h40, 1, 0, 2, 1, 13);
    vecs[13] = mk(1, 0, 0, 0, 1, 'h40, 'h40, 3, 0, 2, 1, 13);
    vecs[14] = mk(1, 1, 0, 0, 1, 'h40, 'h40, 6, 0, 2, 1, 13);
    vecs[15] = mk(1, 1, 0, 0, 1, 'h40, 'h40, 1, 1, 2, 1, 13);
    vecs[16] = mk(1, 1, 0, 0, 1, 'h40, 'h40, 1, 0, 2, 1, 14);
    vecs[17] = mk(1, 1, 0, 0, 1, 'h40, 'h40, 10, 0, 2, 1, 14);
    vecs[18] = mk(1, 0, 0, 0, 1, 'h40, 'h40, 10, 0, 2, 1, 14);
    vecs[19] = mk(0, 0, 0, 0, 1, 'h40, 'h40, 3, 0, 0, 1, 14);
    vecs[20] = mk(1, 0, 0, 0, 0, 'h40, 'h40, 3, 0, 1, 0, 14);
    vecs[21] = mk(1, 0, 0, 0, 0, 'h40, 'h40, 1, 1, 1, 0, 14);

    rst = 1'b1;
    set_in(0, 0, 0, '0, 0, '0, '0);
    cyc(2);
    check("reset_ce", 32'(cpu_ce), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_halted", 32'(halted), 32'd1);
    check("reset_count", 32'(ce_count), 32'd0);
    rst = 1'b0;

    // Run rate, divider reload on a tick, breakpoint, step past, resume.
    for (int i = 0; i < NVEC; i++) begin
      set_in(vecs[i].run_sw, vecs[i].step_btn, vecs[i].div_load, vecs[i].div_value,
             vecs[i].bp_en, vecs[i].bp_addr, vecs[i].pc);
      cyc(vecs[i].ncyc);
      check($sformatf("vec%0d_ce", i), 32'(cpu_ce), 32'(vecs[i].exp_ce));
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
      check($sformatf("vec%0d_count", i), 32'(ce_count), 32'(vecs[i].exp_count));
    end

    // Bouncing button in HALT yields exactly one step.
    set_in(0, 0, 0, '0, 0, '0, '0);
    cyc(5);
    check("halt_state", 32'(state), 32'd0);
    snap = ce_count;
    pulses = 0;
    step_btn = 1'b1; cyc(1); pulses += cpu_ce;
    step_btn = 1'b0; cyc(1); pulses += cpu_ce;
    step_btn = 1'b1;
    for (int k = 0; k < 10; k++) begin cyc(1); pulses += cpu_ce; end
    step_btn = 1'b0;
    for (int k = 0; k < 10; k++) begin cyc(1); pulses += cpu_ce; end
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_count", 32'(ce_count), 32'(snap + 1));

    // Reset during a ce cycle of RUN (div_reg is 0 here, reset restores 3).
    run_sw = 1'b1;
    n = 0;
    while (cpu_ce !== 1'b1 && n < 20) begin cyc(1); n++; end
    if (n >= 20) timeout_fail("rst_wait_ce");
    rst = 1'b1;
    #1;
    check("rst_mid_ce", 32'(cpu_ce), 32'd0);
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_count", 32'(ce_count), 32'd0);
    cyc(2);
    rst = 1'b0;
    gap = 0;
    while (cpu_ce !== 1'b1 && gap < 30) begin cyc(1); gap++; end
    check("rst_first_ce_latency", 32'(gap), 32'd7);
    cyc(1);
    gap = 1;
    while (cpu_ce !== 1'b1 && gap < 30) begin cyc(1); gap++; end
    check("rst_div_period", 32'(gap), 32'd4);

    // Randomized stimulus against the reference model.
    rst = 1'b1;
    set_in(0, 0, 0, '0, 0, PC_W'(5), '0);
    cyc(2);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
      div_load  = ($urandom_range(0, 29) == 0);
      div_value = DIV_W'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) bp_en = ~bp_en;
      pc = PC_W'($urandom_range(0, 7));
      model_step();
      cyc(1);
      check("rnd_ce", 32'(cpu_ce), 32'(m_ce));
      check("rnd_state", 32'(state), 32'(m_state));
      check("rnd_halted", 32'(halted), 32'(m_state != M_RUN));
      check("rnd_count", 32'(ce_count), 32'(m_count));
    end

    // ce_count wraps from 16'hFFFF to 0.
    rst = 1'b1;
    set_in(0, 0, 0, '0, 0, '0, '0);
    cyc(2);
    rst = 1'b0;
    run_sw = 1'b1; div_load = 1'b1; div_value = '0;
    cyc(1);
    div_load = 1'b0;
    n = 0;
    while (ce_count !== 16'hFFFF && n < 70000) begin cyc(1); n++; end
    if (n >= 70000) timeout_fail("wrap_wait");
    check("wrap_ce_inflight", 32'(cpu_ce), 32'd1);
    cyc(1);
    check("wrap_count", 32'(ce_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
